// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD-to-binary converter.
//   DIGIT_W       : bits per BCD digit
//   bcd_state_e   : converter state encoding
//   min_bin_width : minimum binary width able to hold any NDIG-digit decimal value
package bcd_pkg;

    localparam int unsigned DIGIT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } bcd_state_e;

    // Smallest w with 2^w >= 10^ndig, i.e. ceil(log2(10^ndig)).
    function automatic int unsigned min_bin_width(input int unsigned ndig);
        longint unsigned lim;
        int unsigned     w;
        lim = 64'd1;
        w   = 0;
        for (int unsigned i = 0; i < ndig; i++) begin
            lim = lim * 64'd10;
        end
        while ((64'd1 << w) < lim) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Reverse double-dabble correction cell: a digit that is 8 or more after the
// right shift has 3 subtracted (mod 16).
//   i_digit   : shifted BCD digit
//   o_digit_c : corrected digit (combinational)
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] i_digit,
    output logic [DIGIT_W-1:0] o_digit_c
);

    always_comb begin
        o_digit_c = i_digit;
        if (i_digit >= DIGIT_W'(8)) begin
            o_digit_c = i_digit - DIGIT_W'(3);
        end
    end

endmodule

// File: rtl/bcd_to_bin.sv
// Iterative BCD-to-binary converter (reverse double-dabble, one bit per cycle).
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : input handshake, bcd_in = packed BCD (digit 0 in [3:0])
//   out_valid / out_ready: output handshake
//   bin_out              : binary value (0 when err or when out_valid is low)
//   err                  : some input digit was greater than 9
module bcd_to_bin
    import bcd_pkg::*;
#(
    parameter int unsigned NDIG = 4,
    parameter int unsigned BW   = 14
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DIGIT_W*NDIG-1:0] bcd_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [BW-1:0]           bin_out,
    output logic                    err
);

    localparam int unsigned TW       = DIGIT_W * NDIG;
    localparam int unsigned CW       = $clog2(TW);
    localparam int unsigned MIN_BW   = min_bin_width(NDIG);
    localparam logic [CW-1:0] CNT_LAST = CW'(TW - 1);

    // Elaboration-time parameter legality check.
    if (NDIG < 1 || NDIG > 8) begin : g_bad_ndig
        $error("bcd_to_bin: NDIG out of range 1..8");
    end
    if (BW < MIN_BW) begin : g_bad_bw
        $error("bcd_to_bin: BW too small for NDIG digits");
    end

    bcd_state_e      r_state;
    bcd_state_e      w_state_nxt;
    logic [TW-1:0]   r_bcd;
    logic [TW-1:0]   r_bin;
    logic [CW-1:0]   r_cnt;
    logic            r_err;
    logic [BW-1:0]   r_bin_out;
    logic            r_err_out;
    logic            r_in_ready;
    logic            r_out_valid;

    logic [TW-1:0]   w_bcd_sh;
    logic [TW-1:0]   w_bin_sh;
    logic [TW-1:0]   w_bcd_adj;
    logic            w_last;
    logic            w_err_in;

    // One iteration: shift {bcd, bin} right, then correct each digit.
    assign w_bcd_sh = {1'b0, r_bcd[TW-1:1]};
    assign w_bin_sh = {r_bcd[0], r_bin[TW-1:1]};

    for (genvar g = 0; g < NDIG; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .i_digit   (w_bcd_sh[g*DIGIT_W +: DIGIT_W]),
            .o_digit_c (w_bcd_adj[g*DIGIT_W +: DIGIT_W])
        );
    end

    assign w_last = (r_cnt == CNT_LAST);

    // Any input digit above 9.
    always_comb begin
        w_err_in = 1'b0;
        for (int i = 0; i < int'(NDIG); i++) begin
            if (bcd_in[i*DIGIT_W +: DIGIT_W] > DIGIT_W'(9)) begin
                w_err_in = 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)  w_state_nxt = S_SHIFT;
            S_SHIFT: if (w_last)    w_state_nxt = S_DONE;
            S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath, error latch and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bcd       <= '0;
            r_bin       <= '0;
            r_cnt       <= '0;
            r_err       <= 1'b0;
            r_bin_out   <= '0;
            r_err_out   <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_in_ready  <= (w_state_nxt == S_IDLE);
            r_out_valid <= (w_state_nxt == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_bcd <= bcd_in;
                        r_bin <= '0;
                        r_cnt <= '0;
                        r_err <= w_err_in;
                    end
                end
                S_SHIFT: begin
                    r_bcd <= w_bcd_adj;
                    r_bin <= w_bin_sh;
                    r_cnt <= w_last ? '0 : r_cnt + CW'(1);
                    // Final iteration: publish the result alongside out_valid.
                    if (w_last) begin
                        r_bin_out <= r_err ? '0 : BW'(w_bin_sh);
                        r_err_out <= r_err;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_bin_out <= '0;
                        r_err_out <= 1'b0;
                    end
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign bin_out   = r_bin_out;
    assign err       = r_err_out;

endmodule
